rs_syndrome_calc: RTL and testbench
===================================

// Module: rs_syndrome_calc
// PURPOSE
// - First stage of the RS(15,9) decoder over GF(16), directly downstream of the encoder across the channel.
// - Takes a received 60-bit codeword and evaluates R(x) at alpha^1..alpha^6 to produce six 4-bit syndromes S1..S6.
// - Evaluation is serial, one symbol per clock, by Horner's rule.
// - Flags error-free words so the later key-equation and Chien stages can be skipped.
// PARAMETERS
// - SYM_W  4   symbol width in bits; GF(2^4), primitive poly x^4+x+1, alpha = 4'h2
// - N      15  symbols per codeword
// - NSYN   6   number of syndromes (N-K)
// - Only the defaults are supported. The constants below are derived from them.
// PORTS
// - clk          in   1   rising-edge clock
// - rst_n        in   1   asynchronous active-low reset
// - codeword_in  in   60  received word; symbol i at [4i+3:4i]; symbol 14 is the x^14 coefficient
// - start        in   1   request; sampled on clk, accepted only when busy==0
// - busy         out  1   high while accumulating
// - done         out  1   one-cycle pulse; syndromes and error_free valid from this cycle
// - syndromes    out  24  S_j at [4(j-1)+3:4(j-1)], j=1..6
// - error_free   out  1   1 when all six syndromes are zero; valid with done and held afterwards
// BEHAVIOUR
// - Reset: asynchronous, active-low, single clock. State=IDLE. busy=0, done=0, syndromes=0, error_free=0.
//   Symbol counter and the internal shift register are also cleared.
// - States:
//   - IDLE: start=1 -> latch codeword_in into the shift register, clear accumulators, counter=14, go to ACCUM.
//   - ACCUM: each cycle, for j=1..6, S_j <= gf_mul(S_j, alpha^j) ^ r[cnt].
//     Symbols are consumed highest first (14 down to 0).
//     cnt==0 -> go to DONE.
//   - DONE: done=1 for exactly one cycle, then return to IDLE.
// - busy=1 exactly in ACCUM.
// - Latency: start sampled at edge E. busy is high after E through E+15. done is high for the cycle after edge E+15.
// - Outputs: syndromes and error_free update only when entering DONE. They hold until the next accepted start.
// - Accepted start does not clear the previous results; the new results overwrite them at the next DONE.
// - start while busy=1 or in DONE: ignored, with no queueing. Upstream must wait for busy==0 && done==0.
// - codeword_in is sampled only on the accepted start edge. It may change afterwards.
// - start held high continuously: a new word is accepted in each IDLE cycle. Period is 17 cycles.
// - rst_n low mid-ACCUM: the operation is aborted immediately and all outputs return to their reset values.
//   No done pulse is produced for the aborted word.
// - Arithmetic: GF add is XOR. Multiply is polynomial multiply mod x^4+x+1.
//   Constant multipliers: alpha^1..6 = 2, 4, 8, 3, 6, C (hex).
// - No X propagation: every register has a reset value.
// STRUCTURE
// - Shared package rs_gf16_pkg, also used by the encoder and the later decoder stages. It contains:
//   - SYM_W, N, K=9, NSYN;
//   - localparam array ALPHA_POW[0:14] = 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9;
//   - the function gf16_mul(a,b);
//   - the state enum {IDLE, ACCUM, DONE}.
// - One sub-module, rs_syndrome_cell: a single S_j register with a constant-alpha multiply-accumulate.
//   Parameter J selects ALPHA_POW[J]. It is instantiated six times.
// - The top level holds the FSM, the 4-bit counter, the 60-bit shift register and the zero-detect for error_free.
// TESTING
// - All-zero codeword, start -> done 15 cycles later; syndromes=24'h0, error_free=1.
// - Valid codewords from the golden encoder model: message 36'h123456789 and 36'hFFFFFFFFF.
//   Required: syndromes=0, error_free=1.
// - Single error e=1 at symbol 0 (codeword_in=60'h1) -> every S_j=1.
//   Required: syndromes=24'h111111, error_free=0.
// - Single error e=1 at symbol 1 (60'h10) -> S1..S6 = 2,4,8,3,6,C.
//   Required: syndromes=24'hC63842, error_free=0.
// - Protocol checks:
//   - start pulsed during ACCUM is ignored and the result is unchanged.
//   - Back-to-back starts give done every 17 cycles.
//   - rst_n asserted at cycle 7 of ACCUM -> outputs are 0 immediately and there is no done.
//     A fresh start then completes correctly.
// - Random: 1-3 symbol errors on random valid words. Syndromes must match the reference model. error_free=0.

Source files
------------

// File: rtl/rs_gf16_pkg.sv
// Shared GF(16) definitions for the RS(15,9) encoder and decoder stages.
// Field: GF(2^4), primitive polynomial x^4+x+1, alpha = 4'h2.
package rs_gf16_pkg;

  localparam int SYM_W = 4;
  localparam int N     = 15;
  localparam int K     = 9;
  localparam int NSYN  = 6;

  // alpha^i for i = 0..14
  localparam logic [3:0] ALPHA_POW [0:14] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } rs_state_e;

  // Shift-and-add multiply; x^4 folds back to x+1 (4'h3).
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] prod;
    logic [3:0] shifted;
    prod    = 4'h0;
    shifted = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        prod = prod ^ shifted;
      end else begin
        prod = prod;
      end
      shifted = {shifted[2:0], 1'b0} ^ (shifted[3] ? 4'h3 : 4'h0);
    end
    return prod;
  endfunction

endpackage

// File: rtl/rs_syndrome_cell.sv
// One syndrome accumulator: S <= S * alpha^J + r, evaluated by Horner's rule.
// acc_next exposes the value the register takes on an enabled edge so the
// top level can capture the final syndrome on the same edge as the last symbol.
module rs_syndrome_cell
  import rs_gf16_pkg::*;
#(
  parameter int J = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [SYM_W-1:0] sym,
  output logic [SYM_W-1:0] acc_next
);

  logic [SYM_W-1:0] acc_r;

  assign acc_next = gf16_mul(acc_r, ALPHA_POW[J]) ^ sym;

  // Accumulator register: cleared when a new word is accepted, advanced once per symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 4'h0;
    end else if (clear) begin
      acc_r <= 4'h0;
    end else if (en) begin
      acc_r <= acc_next;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome calculator: serially evaluates R(x) at alpha^1..alpha^6,
// one symbol per clock, highest-order symbol first, and flags error-free words.
module rs_syndrome_calc
  import rs_gf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [59:0] codeword_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [23:0] syndromes,
  output logic        error_free
);

  rs_state_e    state_r;
  logic [3:0]   cnt_r;
  logic [59:0]  shift_r;
  logic [23:0]  syn_next_s;
  logic         clear_s;
  logic         en_s;

  // A start is only honoured from IDLE; that same edge clears the accumulators.
  assign clear_s = (state_r == IDLE) && start;
  assign en_s    = (state_r == ACCUM);

  // Six constant-multiplier cells, S_j uses alpha^j.
  for (genvar g = 0; g < NSYN; g++) begin : g_cell
    rs_syndrome_cell #(.J(g + 1)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear_s),
      .en       (en_s),
      .sym      (shift_r[59:56]),
      .acc_next (syn_next_s[4*g+3:4*g])
    );
  end

  // Control FSM, symbol counter, codeword shift register and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      shift_r    <= 60'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      syndromes  <= 24'h0;
      error_free <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_r <= codeword_in;
            cnt_r   <= 4'd14;
            busy    <= 1'b1;
            state_r <= ACCUM;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          // Top nibble is always the current symbol; shift the next one up.
          shift_r <= {shift_r[55:0], 4'h0};
          if (cnt_r == 4'd0) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            syndromes  <= syn_next_s;
            error_free <= (syn_next_s == 24'h0);
            state_r    <= DONE;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            state_r <= ACCUM;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed self-checking bench for rs_syndrome_calc with an independent
// log/antilog GF(16) model, a systematic RS(15,9) encoder and direct
// (non-Horner) syndrome evaluation.
module tb_rs_syndrome_calc;

  logic        clk;
  logic        rst_n;
  logic [59:0] codeword_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [23:0] syndromes;
  logic        error_free;

  int errors;
  int checks;
  int cyc;

  logic [3:0] exp_t [0:14];
  logic [3:0] gen_t [0:6];

  rs_syndrome_calc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .codeword_in (codeword_in),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .syndromes   (syndromes),
    .error_free  (error_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure done-to-done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int gf_log(input logic [3:0] a);
    int l;
    l = 0;
    for (int i = 0; i < 15; i++) begin
      if (exp_t[i] == a) l = i;
    end
    return l;
  endfunction

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return exp_t[(gf_log(a) + gf_log(b)) % 15];
  endfunction

  // Reference syndromes: S_j = sum_i r_i * alpha^(i*j).
  function automatic logic [23:0] ref_syn(input logic [59:0] cw);
    logic [23:0] res;
    logic [3:0]  s;
    res = 24'h0;
    for (int j = 1; j <= 6; j++) begin
      s = 4'h0;
      for (int i = 0; i < 15; i++) begin
        s = s ^ gmul(cw[4*i +: 4], exp_t[(i * j) % 15]);
      end
      res[4*(j-1) +: 4] = s;
    end
    return res;
  endfunction

  // Systematic encoder: message symbols at x^6..x^14, parity = msg*x^6 mod g(x).
  function automatic logic [59:0] encode(input logic [35:0] msg);
    logic [3:0]  rem [0:5];
    logic [3:0]  fb;
    logic [59:0] cw;
    for (int k = 0; k < 6; k++) rem[k] = 4'h0;
    for (int i = 8; i >= 0; i--) begin
      fb = msg[4*i +: 4] ^ rem[5];
      for (int k = 5; k >= 1; k--) rem[k] = rem[k-1] ^ gmul(fb, gen_t[k]);
      rem[0] = gmul(fb, gen_t[0]);
    end
    cw = {msg, 24'h0};
    for (int k = 0; k < 6; k++) cw[4*k +: 4] = rem[k];
    return cw;
  endfunction

  // Issue one word and wait (bounded) for done; returns the results and latency.
  task automatic run_word(input logic [59:0] cw, output logic [23:0] syn,
                          output logic ef, output int lat);
    @(negedge clk);
    codeword_in = cw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    codeword_in = {$urandom, $urandom};
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    syn = syndromes;
    ef = error_free;
    if (!done) check("done_timeout", done, 1'b1);
  endtask

  logic [59:0] cw;
  logic [23:0] syn;
  logic        ef;
  int          lat;
  int          seen;
  int          t_done [0:2];
  int          nd;

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    start = 1'b0;
    codeword_in = 60'h0;
    rst_n = 1'b0;

    // alpha power table and generator g(x) = prod (x + alpha^j), j=1..6
    exp_t[0] = 4'h1;
    for (int i = 1; i < 15; i++)
      exp_t[i] = {exp_t[i-1][2:0], 1'b0} ^ (exp_t[i-1][3] ? 4'h3 : 4'h0);
    for (int k = 0; k < 7; k++) gen_t[k] = 4'h0;
    gen_t[0] = 4'h1;
    for (int j = 1; j <= 6; j++) begin
      for (int k = 6; k >= 1; k--) gen_t[k] = gen_t[k-1] ^ gmul(gen_t[k], exp_t[j]);
      gen_t[0] = gmul(gen_t[0], exp_t[j]);
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_syn", syndromes, 24'h0);
    check("rst_ef", error_free, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero word, including latency and single-cycle done
    @(negedge clk);
    codeword_in = 60'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("zero_latency", lat, 16);
    check("zero_syn", syndromes, 24'h0);
    check("zero_ef", error_free, 1'b1);
    check("zero_busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("zero_syn_held", syndromes, 24'h0);

    // Valid codewords
    run_word(encode(36'h123456789), syn, ef, lat);
    check("enc1_syn", syn, 24'h0);
    check("enc1_ef", ef, 1'b1);
    run_word(encode(36'hFFFFFFFFF), syn, ef, lat);
    check("encF_syn", syn, 24'h0);
    check("encF_ef", ef, 1'b1);

    // Single errors at symbols 0 and 1
    run_word(60'h1, syn, ef, lat);
    check("e0_syn", syn, 24'h111111);
    check("e0_ef", ef, 1'b0);
    run_word(60'h10, syn, ef, lat);
    check("e1_syn", syn, 24'hC63842);
    check("e1_ef", ef, 1'b0);
    check("e1_latency", lat, 16);

    // start pulsed during ACCUM must be ignored
    @(negedge clk);
    codeword_in = 60'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    codeword_in = 60'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 6;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign_latency", lat, 16);
    check("ign_syn", syndromes, 24'h111111);
    @(negedge clk);
    check("ign_no_restart", busy, 1'b0);

    // Back-to-back: start held high, done every 17 cycles
    @(negedge clk);
    codeword_in = 60'h10;
    start = 1'b1;
    nd = 0;
    for (int n = 0; n < 70 && nd < 3; n++) begin
      @(negedge clk);
      if (done) begin
        t_done[nd] = cyc;
        nd++;
        check("b2b_syn", syndromes, 24'hC63842);
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", nd, 3);
    if (nd == 3) begin
      check("b2b_period1", t_done[1] - t_done[0], 17);
      check("b2b_period2", t_done[2] - t_done[1], 17);
    end
    repeat (3) @(negedge clk);

    // Reset in the middle of ACCUM
    @(negedge clk);
    codeword_in = 60'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_syn", syndromes, 24'h0);
    check("midrst_ef", error_free, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_word(60'h10, syn, ef, lat);
    check("after_rst_syn", syn, 24'hC63842);
    check("after_rst_lat", lat, 16);

    // Random valid words with 1-3 symbol errors
    for (int t = 0; t < 6; t++) begin
      int nerr;
      int pos [0:2];
      logic [3:0] v;
      cw = encode({$urandom, 4'($urandom)});
      nerr = $urandom_range(1, 3);
      for (int e = 0; e < nerr; e++) begin
        bit dup;
        do begin
          pos[e] = $urandom_range(0, 14);
          dup = 1'b0;
          for (int q = 0; q < e; q++) if (pos[q] == pos[e]) dup = 1'b1;
        end while (dup);
        v = 4'($urandom_range(1, 15));
        cw[4*pos[e] +: 4] = cw[4*pos[e] +: 4] ^ v;
      end
      run_word(cw, syn, ef, lat);
      check("rand_syn", syn, ref_syn(cw));
      check("rand_ef", ef, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
